mcu_bus_engine: RTL and testbench

Parametrised byte-serial command engine between the STM32 parallel bus and the FPGA datapath; successor to the fixed-layout MCU interface. Decodes a command byte on each DATA_SYNC and serves one of several transactions at one byte per clk_in cycle. The transactions are bus test, auto-incrementing register write, status read, TX IQ load, streaming RX IQ for up to four receivers, and info read. RX samples are taken from an upstream FIFO through a valid/ready handshake, with sticky underrun reporting.

---
 rtl/mcu_bus_engine.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_mcu_bus_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_bus_engine.sv
// mcu_bus_engine
//   Byte-serial command engine between the MCU parallel bus and the FPGA
//   datapath. A command byte is taken on every DATA_SYNC. The engine then
//   moves one byte per clk_in cycle for one of these transactions: bus test,
//   auto-incrementing register write, status read, TX IQ load, streaming
//   RX IQ, or info read.
//
// Ports
//   clk_in, reset_n        clock (rising edge), async active-low reset
//   DATA_SYNC              command strobe (DATA_BUS_IN holds a command byte)
//   DATA_BUS_IN/OUT, _OE   MCU bus byte in, registered byte out, drive enable
//   rx_iq_data/valid/ready upstream RX frame FIFO, one-cycle pop on ready
//   rx_chan_mask           RX channels to stream (bit 0 forced on)
//   ADC_OTR, DAC_OTR       overrange flags reported in status byte 0
//   tx_i, tx_q, tx_iq_valid  TX sample pair and its one-cycle update pulse
//   reg_addr/wdata/we      register write port, one-cycle we pulse
//   stage_debug            current state encoding
module mcu_bus_engine #(
  parameter int          RX_CHANNELS  = 2,
  parameter int          SAMPLE_WIDTH = 24,
  parameter int          TX_WIDTH     = 24,
  parameter logic [23:0] INFO_ID      = 24'h060800
) (
  input  logic                                    clk_in,
  input  logic                                    reset_n,
  input  logic                                    DATA_SYNC,
  input  logic [7:0]                              DATA_BUS_IN,
  output logic [7:0]                              DATA_BUS_OUT,
  output logic                                    DATA_BUS_OE,
  input  logic [2*RX_CHANNELS*SAMPLE_WIDTH-1:0]   rx_iq_data,
  input  logic                                    rx_iq_valid,
  output logic                                    rx_iq_ready,
  input  logic [RX_CHANNELS-1:0]                  rx_chan_mask,
  input  logic                                    ADC_OTR,
  input  logic                                    DAC_OTR,
  output logic [TX_WIDTH-1:0]                     tx_i,
  output logic [TX_WIDTH-1:0]                     tx_q,
  output logic                                    tx_iq_valid,
  output logic [7:0]                              reg_addr,
  output logic [7:0]                              reg_wdata,
  output logic                                    reg_we,
  output logic [3:0]                              stage_debug
);

  localparam int SB = SAMPLE_WIDTH / 8;
  localparam int TB = TX_WIDTH / 8;
  localparam int FW = 2 * RX_CHANNELS * SAMPLE_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_TEST_RD  = 4'd1,
    S_TEST_WR  = 4'd2,
    S_REG_ADDR = 4'd3,
    S_REG_DATA = 4'd4,
    S_STAT     = 4'd5,
    S_TXIQ     = 4'd6,
    S_RXIQ     = 4'd7,
    S_INFO     = 4'd8
  } state_t;

  // Registered state and outputs (q) and their next values (d).
  state_t                    state, state_d;
  logic [3:0]                cnt, cnt_d;
  logic [7:0]                test_byte, test_byte_d;
  logic [7:0]                ptr, ptr_d;
  logic [2*TX_WIDTH-9:0]     tx_sr, tx_sr_d;
  logic [FW-1:0]             shadow, shadow_d;
  logic [3:0]                mask_q, mask_q_d;
  logic                      underrun, underrun_d;
  logic                      rx_first, rx_first_d;
  logic [1:0]                rx_chan, rx_chan_d;
  logic [3:0]                rx_b, rx_b_d;
  logic [7:0]                bus_out_d;
  logic                      oe_d, ready_d, txv_d, rwe_d;
  logic [TX_WIDTH-1:0]       txi_d, txq_d;
  logic [7:0]                raddr_d, rwdata_d;

  // RX byte selection helpers.
  logic [FW-1:0]             cur_frame;
  logic [3:0]                cur_mask;
  logic [1:0]                cur_chan;
  logic [3:0]                cur_b;
  logic [SAMPLE_WIDTH-1:0]   rx_sample;
  logic [7:0]                rx_byte;
  logic                      last_in_chan, has_next, frame_end;
  logic [1:0]                nxt_chan;
  logic [2*TX_WIDTH-1:0]     tx_full;
  logic                      ur_set, ur_clr;

  assign stage_debug = state;
  assign tx_full     = {tx_sr, DATA_BUS_IN};

  // The first byte of every RX frame is served on the latch edge itself, so
  // it reads the live FIFO word (or the shadow on underrun) and the live
  // mask. Later bytes come from the shadow and the mask captured at latch.
  always_comb begin
    // NOTE: every combinational output is given a default first so that no
    // path through the case statements can infer a latch.
    cur_frame = shadow;
    cur_mask  = mask_q;
    cur_chan  = rx_chan;
    cur_b     = rx_b;
    if (rx_first) begin
      cur_frame = rx_iq_valid ? rx_iq_data : shadow;
      cur_mask  = 4'(rx_chan_mask) | 4'b0001;
      cur_chan  = 2'd0;
      cur_b     = 4'd0;
    end

    // Bytes 0..SB-1 of a channel are Q, bytes SB..2SB-1 are I, MSB first.
    if (int'(cur_b) < SB) begin
      rx_sample = SAMPLE_WIDTH'(cur_frame >> ((2 * int'(cur_chan) + 1) * SAMPLE_WIDTH));
      rx_byte   = 8'(rx_sample >> (SAMPLE_WIDTH - 8 - 8 * int'(cur_b)));
    end else begin
      rx_sample = SAMPLE_WIDTH'(cur_frame >> (2 * int'(cur_chan) * SAMPLE_WIDTH));
      rx_byte   = 8'(rx_sample >> (SAMPLE_WIDTH - 8 - 8 * (int'(cur_b) - SB)));
    end

    // Lowest enabled channel above the current one; the descending loop
    // leaves the smallest match in nxt_chan.
    has_next = 1'b0;
    nxt_chan = cur_chan;
    for (int i = 3; i >= 0; i--) begin
      if (i > int'(cur_chan) && cur_mask[i]) begin
        has_next = 1'b1;
        nxt_chan = 2'(i);
      end
    end
    last_in_chan = (int'(cur_b) == 2 * SB - 1);
    frame_end    = last_in_chan && !has_next;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    test_byte_d = test_byte;
    ptr_d       = ptr;
    tx_sr_d     = tx_sr;
    shadow_d    = shadow;
    mask_q_d    = mask_q;
    rx_first_d  = rx_first;
    rx_chan_d   = rx_chan;
    rx_b_d      = rx_b;
    bus_out_d   = DATA_BUS_OUT;
    oe_d        = DATA_BUS_OE;
    txi_d       = tx_i;
    txq_d       = tx_q;
    raddr_d     = reg_addr;
    rwdata_d    = reg_wdata;
    ready_d     = 1'b0;
    txv_d       = 1'b0;
    rwe_d       = 1'b0;
    ur_set      = 1'b0;
    ur_clr      = 1'b0;

    if (DATA_SYNC) begin
      cnt_d      = 4'd0;
      rx_first_d = 1'b1;
      oe_d       = 1'b0;
      case (DATA_BUS_IN)
        8'd0:    state_d = S_TEST_RD;
        8'd1:    state_d = S_REG_ADDR;
        8'd2:    begin state_d = S_STAT; oe_d = 1'b1; end
        8'd3:    state_d = S_TXIQ;
        8'd4:    begin state_d = S_RXIQ; oe_d = 1'b1; ready_d = 1'b1; end
        8'd8:    begin state_d = S_INFO; oe_d = 1'b1; end
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state)
        S_TEST_RD: begin
          oe_d        = 1'b0;
          test_byte_d = DATA_BUS_IN;
          state_d     = S_TEST_WR;
        end
        S_TEST_WR: begin
          oe_d      = 1'b1;
          bus_out_d = test_byte;
          state_d   = S_TEST_RD;
        end
        S_REG_ADDR: begin
          ptr_d   = DATA_BUS_IN;
          state_d = S_REG_DATA;
        end
        S_REG_DATA: begin
          rwe_d    = 1'b1;
          raddr_d  = ptr;
          rwdata_d = DATA_BUS_IN;
          ptr_d    = ptr + 8'd1;
        end
        S_STAT: begin
          cnt_d = cnt + 4'd1;
          case (cnt)
            4'd0: begin
              bus_out_d = {5'b0, underrun, DAC_OTR, ADC_OTR};
              ur_clr    = 1'b1;
            end
            4'd1:    bus_out_d = 8'(RX_CHANNELS);
            4'd2:    bus_out_d = 8'(SAMPLE_WIDTH);
            default: begin oe_d = 1'b0; state_d = S_IDLE; end
          endcase
        end
        S_INFO: begin
          cnt_d = cnt + 4'd1;
          case (cnt)
            4'd0:    bus_out_d = INFO_ID[23:16];
            4'd1:    bus_out_d = INFO_ID[15:8];
            4'd2:    bus_out_d = INFO_ID[7:0];
            default: begin oe_d = 1'b0; state_d = S_IDLE; end
          endcase
        end
        S_TXIQ: begin
          tx_sr_d = tx_full[2*TX_WIDTH-9:0];
          cnt_d   = cnt + 4'd1;
          if (int'(cnt) == 2 * TB - 1) begin
            txq_d   = tx_full[2*TX_WIDTH-1:TX_WIDTH];
            txi_d   = tx_full[TX_WIDTH-1:0];
            txv_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_RXIQ: begin
          bus_out_d = rx_byte;
          if (rx_first) begin
            shadow_d = cur_frame;
            mask_q_d = cur_mask;
            ur_set   = !rx_iq_valid;
          end
          rx_first_d = 1'b0;
          if (frame_end) begin
            // Pop now so the next frame is latched with its byte 0: no gap.
            ready_d    = 1'b1;
            rx_first_d = 1'b1;
          end else if (last_in_chan) begin
            rx_chan_d = nxt_chan;
            rx_b_d    = 4'd0;
          end else begin
            rx_chan_d = cur_chan;
            rx_b_d    = cur_b + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // A fresh underrun on the clearing edge wins.
  assign underrun_d = (underrun & ~ur_clr) | ur_set;

  // NOTE: the frame shadow is reset because an underrun straight after reset
  // must resend a defined all-zero frame.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      test_byte    <= '0;
      ptr          <= '0;
      tx_sr        <= '0;
      shadow       <= '0;
      mask_q       <= 4'b0001;
      underrun     <= 1'b0;
      rx_first     <= 1'b1;
      rx_chan      <= '0;
      rx_b         <= '0;
      DATA_BUS_OUT <= '0;
      DATA_BUS_OE  <= 1'b0;
      rx_iq_ready  <= 1'b0;
      tx_i         <= '0;
      tx_q         <= '0;
      tx_iq_valid  <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_we       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state        <= state_d;
      cnt          <= cnt_d;
      test_byte    <= test_byte_d;
      ptr          <= ptr_d;
      tx_sr        <= tx_sr_d;
      shadow       <= shadow_d;
      mask_q       <= mask_q_d;
      underrun     <= underrun_d;
      rx_first     <= rx_first_d;
      rx_chan      <= rx_chan_d;
      rx_b         <= rx_b_d;
      DATA_BUS_OUT <= bus_out_d;
      DATA_BUS_OE  <= oe_d;
      rx_iq_ready  <= ready_d;
      tx_i         <= txi_d;
      tx_q         <= txq_d;
      tx_iq_valid  <= txv_d;
      reg_addr     <= raddr_d;
      reg_wdata    <= rwdata_d;
      reg_we       <= rwe_d;
    end
  end

endmodule

// File: tb/tb_mcu_bus_engine.sv
// Directed testbench for mcu_bus_engine with default parameters
// (2 RX channels, 24-bit samples, 24-bit TX, INFO_ID 060800).
// Inputs change and outputs are checked on the falling edge of clk_in.
module tb_mcu_bus_engine;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        DATA_SYNC;
  logic [7:0]  DATA_BUS_IN;
  logic [7:0]  DATA_BUS_OUT;
  logic        DATA_BUS_OE;
  logic [95:0] rx_iq_data;
  logic        rx_iq_valid;
  logic        rx_iq_ready;
  logic [1:0]  rx_chan_mask;
  logic        ADC_OTR, DAC_OTR;
  logic [23:0] tx_i, tx_q;
  logic        tx_iq_valid;
  logic [7:0]  reg_addr, reg_wdata;
  logic        reg_we;
  logic [3:0]  stage_debug;

  int total = 0;
  int bad   = 0;

  mcu_bus_engine dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .DATA_SYNC    (DATA_SYNC),
    .DATA_BUS_IN  (DATA_BUS_IN),
    .DATA_BUS_OUT (DATA_BUS_OUT),
    .DATA_BUS_OE  (DATA_BUS_OE),
    .rx_iq_data   (rx_iq_data),
    .rx_iq_valid  (rx_iq_valid),
    .rx_iq_ready  (rx_iq_ready),
    .rx_chan_mask (rx_chan_mask),
    .ADC_OTR      (ADC_OTR),
    .DAC_OTR      (DAC_OTR),
    .tx_i         (tx_i),
    .tx_q         (tx_q),
    .tx_iq_valid  (tx_iq_valid),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .stage_debug  (stage_debug)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    DATA_SYNC   = 1'b1;
    DATA_BUS_IN = cmd;
    tick();
    DATA_SYNC   = 1'b0;
  endtask

  // Frame layout per channel c: Q at [(2c+1)*24 +: 24], I at [2c*24 +: 24].
  localparam logic [95:0] FRAME1 = {24'h000001, 24'h000002, 24'h123456, 24'h789ABC};
  localparam logic [95:0] FRAME2 = {24'h010203, 24'h040506, 24'hAABBCC, 24'hDDEEFF};

  logic [7:0] exp1 [12];
  logic [7:0] exp2 [6];

  initial begin
    exp1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
             8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02};
    exp2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

    reset_n      = 1'b0;
    DATA_SYNC    = 1'b0;
    DATA_BUS_IN  = 8'h00;
    rx_iq_data   = '0;
    rx_iq_valid  = 1'b0;
    rx_chan_mask = 2'b11;
    ADC_OTR      = 1'b0;
    DAC_OTR      = 1'b0;
    tick();
    tick();
    check("rst_out",   {40'd0, DATA_BUS_OUT}, 48'd0);
    check("rst_oe",    {47'd0, DATA_BUS_OE}, 48'd0);
    check("rst_tx",    {tx_q, tx_i}, 48'd0);
    check("rst_pulse", {45'd0, tx_iq_valid, reg_we, rx_iq_ready}, 48'd0);
    check("rst_reg",   {32'd0, reg_addr, reg_wdata}, 48'd0);
    check("rst_stage", {44'd0, stage_debug}, 48'd0);
    reset_n = 1'b1;
    tick();

    // ---- Bus test: A5 captured at E1 / driven after E2; 3C at E3 / E4.
    send_cmd(8'd0);
    check("bt_stage0", {44'd0, stage_debug}, 48'd1);
    check("bt_oe0",    {47'd0, DATA_BUS_OE}, 48'd0);
    DATA_BUS_IN = 8'hA5;
    tick();
    check("bt_oe1", {47'd0, DATA_BUS_OE}, 48'd0);
    DATA_BUS_IN = 8'h00;
    tick();
    check("bt_oe2",  {47'd0, DATA_BUS_OE}, 48'd1);
    check("bt_out2", {40'd0, DATA_BUS_OUT}, 48'hA5);
    DATA_BUS_IN = 8'h3C;
    tick();
    check("bt_oe3", {47'd0, DATA_BUS_OE}, 48'd0);
    DATA_BUS_IN = 8'h00;
    tick();
    check("bt_oe4",  {47'd0, DATA_BUS_OE}, 48'd1);
    check("bt_out4", {40'd0, DATA_BUS_OUT}, 48'h3C);

    // ---- Register write with pointer wrap FE, FF, 00.
    send_cmd(8'd1);
    check("rw_oe", {47'd0, DATA_BUS_OE}, 48'd0);
    DATA_BUS_IN = 8'hFE;
    tick();
    check("rw_we_addr", {47'd0, reg_we}, 48'd0);
    DATA_BUS_IN = 8'h11;
    tick();
    check("rw_w0", {31'd0, reg_we, reg_addr, reg_wdata}, {31'd0, 1'b1, 8'hFE, 8'h11});
    DATA_BUS_IN = 8'h22;
    tick();
    check("rw_w1", {31'd0, reg_we, reg_addr, reg_wdata}, {31'd0, 1'b1, 8'hFF, 8'h22});
    DATA_BUS_IN = 8'h33;
    tick();
    check("rw_w2", {31'd0, reg_we, reg_addr, reg_wdata}, {31'd0, 1'b1, 8'h00, 8'h33});
    send_cmd(8'h0F);
    check("rw_abort_we",    {47'd0, reg_we}, 48'd0);
    check("rw_abort_stage", {44'd0, stage_debug}, 48'd0);

    // ---- TX IQ: Q=000001, I=FFFFFF.
    send_cmd(8'd3);
    DATA_BUS_IN = 8'h00; tick();
    DATA_BUS_IN = 8'h00; tick();
    DATA_BUS_IN = 8'h01; tick();
    DATA_BUS_IN = 8'hFF; tick();
    DATA_BUS_IN = 8'hFF; tick();
    check("tx_nopulse", {47'd0, tx_iq_valid}, 48'd0);
    DATA_BUS_IN = 8'hFF; tick();
    check("tx_pulse", {47'd0, tx_iq_valid}, 48'd1);
    check("tx_data",  {tx_q, tx_i}, {24'h000001, 24'hFFFFFF});
    check("tx_stage", {44'd0, stage_debug}, 48'd0);
    tick();
    check("tx_pulse_end", {47'd0, tx_iq_valid}, 48'd0);
    // Aborted load after byte 3 leaves the sample untouched.
    send_cmd(8'd3);
    DATA_BUS_IN = 8'h12; tick();
    DATA_BUS_IN = 8'h34; tick();
    DATA_BUS_IN = 8'h56; tick();
    DATA_BUS_IN = 8'h78; tick();
    send_cmd(8'h0F);
    tick();
    check("tx_abort_data",  {tx_q, tx_i}, {24'h000001, 24'hFFFFFF});
    check("tx_abort_pulse", {47'd0, tx_iq_valid}, 48'd0);

    // ---- RX IQ streaming.
    rx_iq_data  = FRAME1;
    rx_iq_valid = 1'b1;
    send_cmd(8'd4);
    check("rx_pop0",   {47'd0, rx_iq_ready}, 48'd1);
    check("rx_oe",     {47'd0, DATA_BUS_OE}, 48'd1);
    check("rx_stage",  {44'd0, stage_debug}, 48'd7);
    tick();
    check("rx_f1_b0",  {40'd0, DATA_BUS_OUT}, {40'd0, exp1[0]});
    check("rx_f1_rdy0", {47'd0, rx_iq_ready}, 48'd0);
    // Frame 1 is latched; change data and mask mid-frame.
    rx_iq_data   = FRAME2;
    rx_chan_mask = 2'b01;
    for (int k = 1; k < 12; k++) begin
      tick();
      check($sformatf("rx_f1_b%0d", k), {40'd0, DATA_BUS_OUT}, {40'd0, exp1[k]});
      check($sformatf("rx_f1_rdy%0d", k), {47'd0, rx_iq_ready}, {47'd0, (k == 11)});
    end
    // Frame 2 (mask 01): 6 bytes, no gap.
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rx_f2_b%0d", k), {40'd0, DATA_BUS_OUT}, {40'd0, exp2[k]});
      check($sformatf("rx_f2_rdy%0d", k), {47'd0, rx_iq_ready}, {47'd0, (k == 5)});
    end
    // Underrun at the next pop: frame 2 is repeated.
    rx_iq_valid = 1'b0;
    rx_iq_data  = FRAME1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rx_ur_b%0d", k), {40'd0, DATA_BUS_OUT}, {40'd0, exp2[k]});
    end

    // ---- Abort into INFO.
    send_cmd(8'd8);
    check("info_stage", {44'd0, stage_debug}, 48'd8);
    check("info_rdy",   {47'd0, rx_iq_ready}, 48'd0);
    check("info_oe",    {47'd0, DATA_BUS_OE}, 48'd1);
    tick();
    check("info_b0", {40'd0, DATA_BUS_OUT}, 48'h06);
    tick();
    check("info_b1", {40'd0, DATA_BUS_OUT}, 48'h08);
    tick();
    check("info_b2", {40'd0, DATA_BUS_OUT}, 48'h00);
    tick();
    check("info_end_oe",    {47'd0, DATA_BUS_OE}, 48'd0);
    check("info_end_stage", {44'd0, stage_debug}, 48'd0);

    // ---- STAT: underrun reported once, then cleared.
    send_cmd(8'd2);
    check("st_oe", {47'd0, DATA_BUS_OE}, 48'd1);
    tick();
    check("st_b0", {40'd0, DATA_BUS_OUT}, 48'h04);
    tick();
    check("st_b1", {40'd0, DATA_BUS_OUT}, 48'h02);
    tick();
    check("st_b2", {40'd0, DATA_BUS_OUT}, 48'h18);
    tick();
    check("st_end_oe", {47'd0, DATA_BUS_OE}, 48'd0);
    ADC_OTR = 1'b1;
    DAC_OTR = 1'b1;
    send_cmd(8'd2);
    tick();
    check("st2_b0", {40'd0, DATA_BUS_OUT}, 48'h03);

    // ---- Asynchronous reset mid-STAT.
    send_cmd(8'd2);
    tick();
    check("st3_oe", {47'd0, DATA_BUS_OE}, 48'd1);
    #1 reset_n = 1'b0;
    #1;
    check("ar_out",   {40'd0, DATA_BUS_OUT}, 48'd0);
    check("ar_oe",    {47'd0, DATA_BUS_OE}, 48'd0);
    check("ar_tx",    {tx_q, tx_i}, 48'd0);
    check("ar_reg",   {29'd0, reg_we, reg_addr, reg_wdata, tx_iq_valid, rx_iq_ready}, 48'd0);
    check("ar_stage", {44'd0, stage_debug}, 48'd0);
    tick();
    reset_n = 1'b1;
    ADC_OTR = 1'b0;
    DAC_OTR = 1'b0;
    tick();

    // ---- Underrun right after reset sends the zero shadow.
    rx_chan_mask = 2'b11;
    rx_iq_valid  = 1'b0;
    send_cmd(8'd4);
    tick();
    check("rx_zero_b0", {40'd0, DATA_BUS_OUT}, 48'h00);
    send_cmd(8'd2);
    tick();
    check("st4_b0", {40'd0, DATA_BUS_OUT}, 48'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
